// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage with combinational read/bypass,
// registered write commit, trap/MRET state updates and 64-bit counters.
// Optional feature macro: CSR_COUNTER_EN (mcycle/minstret and user aliases).
// Ports: clk_in, reset_in (async, active-high);
//   read:  csr_raddr_in -> csr_rdata_out, csr_illegal_out (combinational);
//   write: csr_we_in, csr_waddr_in, csr_wdata_in (commit on next edge);
//   trap:  trap_valid_in, trap_epc_in, trap_cause_in; mret_in; instret_in;
//   state: mtvec_out, mepc_out, mie_global_out.
module csr_regfile (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [11:0] csr_raddr_in,
   output logic [31:0] csr_rdata_out,
   output logic        csr_illegal_out,
   input  logic        csr_we_in,
   input  logic [11:0] csr_waddr_in,
   input  logic [31:0] csr_wdata_in,
   input  logic        trap_valid_in,
   input  logic [31:0] trap_epc_in,
   input  logic [31:0] trap_cause_in,
   input  logic        mret_in,
   input  logic        instret_in,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out,
   output logic        mie_global_out
);

   localparam int DATA_WIDTH  = 32;
   localparam int RDATA_WIDTH = 32;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MHARTID  = 12'hF14;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_MINSTRET = 12'hB02;
   localparam logic [11:0] A_MINSTRETH= 12'hB82;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_INSTRET  = 12'hC02;
   localparam logic [11:0] A_INSTRETH = 12'hC82;

   localparam logic [RDATA_WIDTH-1:0] MISA_VAL = 32'h4000_0100;

   logic                  r_mie;
   logic                  r_mpie;
   logic [DATA_WIDTH-1:0] r_mie_reg;
   logic [DATA_WIDTH-1:0] r_mtvec;
   logic [DATA_WIDTH-1:0] r_mscratch;
   logic [DATA_WIDTH-1:0] r_mepc;
   logic [DATA_WIDTH-1:0] r_mcause;

   logic [DATA_WIDTH-1:0]  w_mstatus;
   logic [DATA_WIDTH-1:0]  w_wmasked;
   logic [RDATA_WIDTH-1:0] w_rd;
   logic                   w_ill;
   logic                   w_rd_writable;
   logic                   w_bypass;

   // MPP is hardwired to machine mode
   assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

   function automatic logic wr_hit(input logic [11:0] a);
      return csr_we_in && (csr_waddr_in == a);
   endfunction

   // Write data after field masking, as it would be stored
   always_comb begin
      w_wmasked = csr_wdata_in;
      case (csr_waddr_in)
         A_MSTATUS:
            w_wmasked = {19'd0, 2'b11, 3'd0, csr_wdata_in[7],
                         3'd0, csr_wdata_in[3], 3'd0};
         A_MTVEC: w_wmasked = {csr_wdata_in[31:2], 2'b00};
         A_MEPC:  w_wmasked = {csr_wdata_in[31:1], 1'b0};
         default: w_wmasked = csr_wdata_in;
      endcase
   end

`ifdef CSR_COUNTER_EN
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_mcycle   <= 64'd0;
         r_minstret <= 64'd0;
      end else begin
         // A write to either half suppresses the whole counter's increment
         if (wr_hit(A_MCYCLE))
            r_mcycle[31:0] <= csr_wdata_in;
         else if (wr_hit(A_MCYCLEH))
            r_mcycle[63:32] <= csr_wdata_in;
         else
            r_mcycle <= r_mcycle + 64'd1;

         if (wr_hit(A_MINSTRET))
            r_minstret[31:0] <= csr_wdata_in;
         else if (wr_hit(A_MINSTRETH))
            r_minstret[63:32] <= csr_wdata_in;
         else if (instret_in)
            r_minstret <= r_minstret + 64'd1;
      end
   end
`else
   logic w_unused_instret;
   assign w_unused_instret = instret_in;
`endif

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mie_reg  <= '0;
         r_mtvec    <= '0;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
      end else begin
         if (trap_valid_in) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
         end else if (mret_in) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end else if (wr_hit(A_MSTATUS)) begin
            r_mie  <= csr_wdata_in[3];
            r_mpie <= csr_wdata_in[7];
         end

         if (trap_valid_in) begin
            r_mepc   <= {trap_epc_in[31:1], 1'b0};
            r_mcause <= trap_cause_in;
         end else begin
            if (wr_hit(A_MEPC))
               r_mepc <= {csr_wdata_in[31:1], 1'b0};
            if (wr_hit(A_MCAUSE))
               r_mcause <= csr_wdata_in;
         end

         if (wr_hit(A_MIE))      r_mie_reg  <= csr_wdata_in;
         if (wr_hit(A_MTVEC))    r_mtvec    <= {csr_wdata_in[31:2], 2'b00};
         if (wr_hit(A_MSCRATCH)) r_mscratch <= csr_wdata_in;
      end
   end

   always_comb begin
      w_rd          = '0;
      w_ill         = 1'b0;
      w_rd_writable = 1'b0;
      case (csr_raddr_in)
         A_MSTATUS:  begin w_rd = w_mstatus;  w_rd_writable = 1'b1; end
         A_MISA:     w_rd = MISA_VAL;
         A_MIE:      begin w_rd = r_mie_reg;  w_rd_writable = 1'b1; end
         A_MTVEC:    begin w_rd = r_mtvec;    w_rd_writable = 1'b1; end
         A_MSCRATCH: begin w_rd = r_mscratch; w_rd_writable = 1'b1; end
         A_MEPC:     begin w_rd = r_mepc;     w_rd_writable = 1'b1; end
         A_MCAUSE:   begin w_rd = r_mcause;   w_rd_writable = 1'b1; end
         A_MHARTID:  w_rd = '0;
`ifdef CSR_COUNTER_EN
         A_MCYCLE:    begin w_rd = r_mcycle[31:0];    w_rd_writable = 1'b1; end
         A_MCYCLEH:   begin w_rd = r_mcycle[63:32];   w_rd_writable = 1'b1; end
         A_MINSTRET:  begin w_rd = r_minstret[31:0];  w_rd_writable = 1'b1; end
         A_MINSTRETH: begin w_rd = r_minstret[63:32]; w_rd_writable = 1'b1; end
         A_CYCLE:     w_rd = r_mcycle[31:0];
         A_CYCLEH:    w_rd = r_mcycle[63:32];
         A_INSTRET:   w_rd = r_minstret[31:0];
         A_INSTRETH:  w_rd = r_minstret[63:32];
`endif
         default:    w_ill = 1'b1;
      endcase
   end

   assign w_bypass = w_rd_writable && csr_we_in &&
                     (csr_waddr_in == csr_raddr_in);

   assign csr_rdata_out   = w_bypass ? w_wmasked : w_rd;
   assign csr_illegal_out = w_ill;
   assign mtvec_out       = r_mtvec;
   assign mepc_out        = r_mepc;
   assign mie_global_out  = r_mie;

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed self-checking bench for csr_regfile.
// Counter checks run only when CSR_COUNTER_EN is defined.
module tb_csr_regfile;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic [11:0] csr_raddr_in;
   logic [31:0] csr_rdata_out;
   logic        csr_illegal_out;
   logic        csr_we_in;
   logic [11:0] csr_waddr_in;
   logic [31:0] csr_wdata_in;
   logic        trap_valid_in;
   logic [31:0] trap_epc_in;
   logic [31:0] trap_cause_in;
   logic        mret_in;
   logic        instret_in;
   logic [31:0] mtvec_out;
   logic [31:0] mepc_out;
   logic        mie_global_out;

   int checks = 0;
   int errors = 0;

   csr_regfile dut (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .csr_raddr_in    (csr_raddr_in),
      .csr_rdata_out   (csr_rdata_out),
      .csr_illegal_out (csr_illegal_out),
      .csr_we_in       (csr_we_in),
      .csr_waddr_in    (csr_waddr_in),
      .csr_wdata_in    (csr_wdata_in),
      .trap_valid_in   (trap_valid_in),
      .trap_epc_in     (trap_epc_in),
      .trap_cause_in   (trap_cause_in),
      .mret_in         (mret_in),
      .instret_in      (instret_in),
      .mtvec_out       (mtvec_out),
      .mepc_out        (mepc_out),
      .mie_global_out  (mie_global_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      csr_we_in     = 1'b0;
      csr_waddr_in  = 12'h000;
      csr_wdata_in  = 32'h0;
      trap_valid_in = 1'b0;
      trap_epc_in   = 32'h0;
      trap_cause_in = 32'h0;
      mret_in       = 1'b0;
      instret_in    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      idle();
   endtask

   task automatic rd(input logic [11:0] a, input string tag,
                     input logic [31:0] exp, input logic exp_ill);
      csr_raddr_in = a;
      #1;
      chk(tag, csr_rdata_out, exp);
      chk({tag, "_ill"}, {31'd0, csr_illegal_out}, {31'd0, exp_ill});
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we_in    = 1'b1;
      csr_waddr_in = a;
      csr_wdata_in = d;
   endtask

   initial begin
      reset_in     = 1'b1;
      csr_raddr_in = 12'h000;
      idle();
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b0;
      #1;

      chk("rst_mtvec", mtvec_out, 32'h0);
      chk("rst_mepc", mepc_out, 32'h0);
      chk("rst_mie", {31'd0, mie_global_out}, 32'h0);
      rd(12'h300, "rst_mstatus", 32'h0000_1800, 1'b0);
      rd(12'h301, "misa", 32'h4000_0100, 1'b0);
      rd(12'h7C0, "unimpl", 32'h0, 1'b1);
      rd(12'hF14, "mhartid", 32'h0, 1'b0);

      wr(12'h305, 32'h8000_0103);
      rd(12'h305, "mtvec_bypass", 32'h8000_0100, 1'b0);
      tick();
      chk("mtvec_out", mtvec_out, 32'h8000_0100);
      rd(12'h305, "mtvec_rd", 32'h8000_0100, 1'b0);

      wr(12'h301, 32'h0);
      rd(12'h301, "misa_no_bypass", 32'h4000_0100, 1'b0);
      tick();
      rd(12'h301, "misa_ro", 32'h4000_0100, 1'b0);

      wr(12'h300, 32'h0000_0008);
      tick();
      chk("mie_set", {31'd0, mie_global_out}, 32'h1);
      rd(12'h300, "mstatus_mie", 32'h0000_1808, 1'b0);

      trap_valid_in = 1'b1;
      trap_epc_in   = 32'h0000_1235;
      trap_cause_in = 32'h8000_0007;
      tick();
      chk("trap_mepc", mepc_out, 32'h0000_1234);
      rd(12'h342, "trap_mcause", 32'h8000_0007, 1'b0);
      chk("trap_mie", {31'd0, mie_global_out}, 32'h0);
      rd(12'h300, "trap_mstatus", 32'h0000_1880, 1'b0);

      mret_in = 1'b1;
      tick();
      chk("mret_mie", {31'd0, mie_global_out}, 32'h1);
      rd(12'h300, "mret_mstatus", 32'h0000_1888, 1'b0);

      trap_valid_in = 1'b1;
      trap_epc_in   = 32'h0000_2001;
      trap_cause_in = 32'h0000_0003;
      mret_in       = 1'b1;
      wr(12'h341, 32'hDEAD_BEEF);
      tick();
      chk("trap_wins_mepc", mepc_out, 32'h0000_2000);
      rd(12'h342, "trap_wins_mcause", 32'h0000_0003, 1'b0);
      rd(12'h300, "trap_over_mret", 32'h0000_1880, 1'b0);

      trap_valid_in = 1'b1;
      trap_epc_in   = 32'h0000_3000;
      trap_cause_in = 32'h0000_000B;
      wr(12'h340, 32'h0000_0055);
      tick();
      rd(12'h340, "trap_mscratch", 32'h0000_0055, 1'b0);
      chk("trap2_mepc", mepc_out, 32'h0000_3000);

      wr(12'h341, 32'hDEAD_BEEF);
      tick();
      chk("mepc_wr", mepc_out, 32'hDEAD_BEEE);

      wr(12'h304, 32'h0000_0888);
      tick();
      rd(12'h304, "mie_reg", 32'h0000_0888, 1'b0);

`ifdef CSR_COUNTER_EN
      wr(12'hB00, 32'hFFFF_FFFF);
      tick();
      wr(12'hB80, 32'hFFFF_FFFF);
      tick();
      rd(12'hB00, "mcycle_lo_max", 32'hFFFF_FFFF, 1'b0);
      rd(12'hB80, "mcycle_hi_max", 32'hFFFF_FFFF, 1'b0);
      tick();
      rd(12'hB00, "mcycle_wrap", 32'h0, 1'b0);
      rd(12'hC80, "cycleh_wrap", 32'h0, 1'b0);
      tick();
      rd(12'hC00, "cycle_inc", 32'h0000_0001, 1'b0);

      wr(12'hB02, 32'h0000_0005);
      instret_in = 1'b1;
      tick();
      rd(12'hB02, "minstret_wr", 32'h0000_0005, 1'b0);
      instret_in = 1'b1;
      tick();
      rd(12'hC02, "instret_inc", 32'h0000_0006, 1'b0);
      tick();
      rd(12'hB02, "instret_hold", 32'h0000_0006, 1'b0);
      rd(12'hB82, "minstreth", 32'h0, 1'b0);
`else
      rd(12'hB00, "mcycle_off", 32'h0, 1'b1);
      rd(12'hC82, "instreth_off", 32'h0, 1'b1);
      wr(12'hB00, 32'h1234_5678);
      rd(12'hB00, "mcycle_off_byp", 32'h0, 1'b1);
      tick();
`endif

      wr(12'h340, 32'h0000_1234);
      tick();
      rd(12'h340, "mscratch_pre", 32'h0000_1234, 1'b0);
      #2;
      reset_in = 1'b1;
      rd(12'h340, "async_rst_mscratch", 32'h0, 1'b0);
      chk("async_rst_mtvec", mtvec_out, 32'h0);
      chk("async_rst_mepc", mepc_out, 32'h0);
      chk("async_rst_mie", {31'd0, mie_global_out}, 32'h0);
      @(posedge clk_in);
      #1;
      rd(12'h300, "rst_held_mstatus", 32'h0000_1800, 1'b0);
      reset_in = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode control and status register file: the storage end of the CSR access path. It serves the combinational CSR read that feeds the execute-stage CSR ALU, commits the computed CSR write data one clock later, and owns trap/return state updates and the cycle/instret counters. It sits beside the integer register file, between the execute and write-back stages, and exports trap-vector and return-address state to the fetch/PC logic.

## Interface
- No parameters; widths come from `DATA_WIDTH`/`RDATA_WIDTH` (32).
- clk_in  input  1  core clock; all state updates on rising edge
- reset_in  input  1  asynchronous, active-high reset
- csr_raddr_in  input  12  CSR read address (instruction bits [31:20])
- csr_rdata_out  output  32  read data, combinational from csr_raddr_in
- csr_illegal_out  output  1  csr_raddr_in unimplemented, combinational
- csr_we_in  input  1  write strobe, committed at the next edge
- csr_waddr_in  input  12  write address
- csr_wdata_in  input  32  write data (already merged RW/RS/RC value)
- trap_valid_in  input  1  take trap this cycle
- trap_epc_in  input  32  PC of the trapping instruction
- trap_cause_in  input  32  mcause value
- mret_in  input  1  MRET retiring this cycle
- instret_in  input  1  one instruction retired this cycle
- mtvec_out  output  32  current mtvec
- mepc_out  output  32  current mepc
- mie_global_out  output  1  mstatus.MIE

## Operation
- Registers, addresses and reset values: mstatus 0x300 (only MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11; reset MIE=0, MPIE=0); misa 0x301 read-only 0x4000_0100; mie 0x304 (reset 0); mtvec 0x305 (bits[1:0] forced 0, reset 0); mscratch 0x340 (0); mepc 0x341 (bit0 forced 0, reset 0); mcause 0x342 (0); mhartid 0xF14 read-only 0.
- Counters (see Configuration): mcycle 0xB00/mcycleh 0xB80, minstret 0xB02/minstreth 0xB82, read-only user aliases 0xC00/0xC80/0xC02/0xC82. All reset to 0.
- Read: pure mux on csr_raddr_in. Unimplemented address -> csr_rdata_out=0, csr_illegal_out=1. Read-only addresses read normally, csr_illegal_out=0.
- Bypass: if csr_we_in=1 and csr_waddr_in==csr_raddr_in (writable register), csr_rdata_out returns the masked csr_wdata_in.
- Write: at edge when csr_we_in=1, target register takes csr_wdata_in with field masks above; writes to read-only or unimplemented addresses are dropped silently.
- Trap (trap_valid_in=1): mepc<=trap_epc_in&~1, mcause<=trap_cause_in, MPIE<=MIE, MIE<=0.
- MRET (mret_in=1, trap_valid_in=0): MIE<=MPIE, MPIE<=1.
- Priority: trap > mret > csr write for mstatus/mepc/mcause; a csr write to any other register in the same cycle still commits. mret_in ignored when trap_valid_in=1.
- Counters: 64-bit mcycle +1 every cycle; minstret +1 when instret_in=1; both wrap 0xFFFF_FFFF_FFFF_FFFF -> 0. A csr write to a counter half replaces that half and suppresses the increment of the whole counter that cycle (the other half holds).

## Timing
- Read and illegal flag: zero latency, combinational.
- Write/trap/mret/counter effects: visible one cycle after the edge (mtvec_out, mepc_out, mie_global_out are registered state).
- reset_in asserted at any time clears all state immediately, including mid-trap; outputs read reset values while reset is high.
- No handshake: every strobe is a single-cycle pulse, accepted unconditionally.

## Configuration
- `CSR_COUNTER_EN` defined: counters and their eight addresses implemented as above.
- Not defined: no counter flops; all eight counter addresses read 0 with csr_illegal_out=1; instret_in ignored.

## Test plan
- Reset then read 0x301 -> 0x4000_0100, illegal=0; read 0x7C0 -> 0, illegal=1.
- Write mtvec 0x8000_0103, next cycle read 0x305 and mtvec_out -> 0x8000_0100; same-cycle read of 0x305 during write -> 0x8000_0100 (bypass).
- Set MIE via write 0x300=0x8; trap with epc 0x0000_1235, cause 0x8000_0007 -> mepc 0x1234, mcause 0x8000_0007, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
- Same cycle: trap plus csr write mepc=0xDEAD_BEEF and mscratch=... (separate cycles) -> trap value wins for mepc; concurrent mscratch write 0x55 commits.
- Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF; after two further cycles read mcycle -> 0x0000_0000 then 0x0000_0001 wrap check; with macro undefined, read 0xB00 -> 0, illegal=1.
- Assert reset_in asynchronously between edges after loading mscratch=0x1234 -> mscratch reads 0 before the next edge.
